// File: rtl/tetris_step_ctrl_pkg.sv
// Shared definitions for the falling-block game-step sequencer.
// Holds the FSM state encoding, the one-hot board command payload, board
// constants, the default gravity divider and a saturating score increment.
package tetris_step_ctrl_pkg;

  localparam int unsigned GRID_W              = 12;
  localparam int unsigned GRID_H              = 12;
  localparam int unsigned GRAVITY_DIV_DEFAULT = 25_000_000;
  localparam int unsigned STATE_W             = 3;
  localparam int unsigned SCORE_W             = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SPAWN     = 3'd1,
    ST_SPAWN_CHK = 3'd2,
    ST_FALL      = 3'd3,
    ST_LOCK      = 3'd4,
    ST_SCAN      = 3'd5,
    ST_CLR_WAIT  = 3'd6,
    ST_OVER      = 3'd7
  } step_state_e;

  // Board command payload; the sequencer sets at most one field per cycle.
  typedef struct packed {
    logic mv_left;
    logic mv_right;
    logic mv_down;
    logic lock;
    logic spawn;
    logic clear_all;
    logic clear_row;
  } step_cmd_t;

  // Score increment that sticks at all-ones.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/step_gravity_timer.sv
// Gravity step timer: free-running modulo-GRAVITY_DIV counter.
// Ports:
//   clk, resetn : clock and async active-low reset
//   clr         : force count to zero (wins over en)
//   en          : advance count this cycle, wrapping after GRAVITY_DIV-1
//   tick_c      : combinational, high while count == GRAVITY_DIV-1
module step_gravity_timer
  import tetris_step_ctrl_pkg::*;
#(
  parameter int unsigned GRAVITY_DIV = GRAVITY_DIV_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(GRAVITY_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = (count == CNT_LAST);

  // Counter: clear has priority, otherwise count and wrap on tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tetris_step_ctrl.sv
// Game-step sequencer for the falling-block board. Converts button edges and
// the gravity timer into single-cycle board commands and walks each piece
// through spawn, fall, lock, row-clear scan and respawn; tracks game over and
// the cleared-row score.
// Ports:
//   clk, resetn                      : clock, async active-low reset
//   btn_left/right/down/up           : synchronized button levels
//   left/right/down_bound, overlap   : datapath collision status
//   line_full                        : per-row full flags (row GRID_H-1 = bottom)
//   mv_left/right/down, lock, spawn,
//   clear_all, clear_row             : registered one-cycle board commands
//   clear_idx                        : row to delete while clear_row is high
//   game_over, score, state_o        : status and debug state
module tetris_step_ctrl #(
  parameter int unsigned GRID_H      = tetris_step_ctrl_pkg::GRID_H,
  parameter int unsigned GRAVITY_DIV = tetris_step_ctrl_pkg::GRAVITY_DIV_DEFAULT,
  parameter int unsigned ROW_W       = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_down,
  input  logic              btn_up,
  input  logic              left_bound,
  input  logic              right_bound,
  input  logic              down_bound,
  input  logic              overlap,
  input  logic [GRID_H-1:0] line_full,
  output logic              mv_left,
  output logic              mv_right,
  output logic              mv_down,
  output logic              lock,
  output logic              spawn,
  output logic              clear_all,
  output logic              clear_row,
  output logic [ROW_W-1:0]  clear_idx,
  output logic              game_over,
  output logic [15:0]       score,
  output logic [2:0]        state_o
);

  import tetris_step_ctrl_pkg::*;

  localparam logic [ROW_W-1:0] ROW_BOTTOM = ROW_W'(GRID_H - 1);

  step_state_e        state, state_next;
  step_cmd_t          cmd, cmd_next;
  logic [ROW_W-1:0]   clear_idx_next;
  logic               game_over_next;
  logic [SCORE_W-1:0] score_next;
  logic [ROW_W-1:0]   scan_row, scan_row_next;

  // Previous button levels, packed {up, down, left, right}.
  logic [3:0] btn_q;
  logic       up_edge, down_edge, left_edge, right_edge;

  logic tmr_clr, tmr_en, tick_c;

  assign up_edge    = btn_up    & ~btn_q[3];
  assign down_edge  = btn_down  & ~btn_q[2];
  assign left_edge  = btn_left  & ~btn_q[1];
  assign right_edge = btn_right & ~btn_q[0];

  step_gravity_timer #(
    .GRAVITY_DIV (GRAVITY_DIV)
  ) u_gravity (
    .clk    (clk),
    .resetn (resetn),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tick_c (tick_c)
  );

  // Next-state, next-command and bookkeeping decisions.
  always_comb begin
    state_next     = state;
    cmd_next       = '0;
    clear_idx_next = '0;
    scan_row_next  = scan_row;
    score_next     = score;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (up_edge) begin
          cmd_next.clear_all = 1'b1;
          score_next         = '0;
          state_next         = ST_SPAWN;
        end
      end

      ST_SPAWN: begin
        cmd_next.spawn = 1'b1;
        state_next     = ST_SPAWN_CHK;
      end

      // The new piece is in place by now; a collision here ends the game.
      ST_SPAWN_CHK: begin
        if (overlap) begin
          state_next = ST_OVER;
        end else begin
          tmr_clr    = 1'b1;
          state_next = ST_FALL;
        end
      end

      // One command per cycle: gravity, then soft drop, then sideways moves.
      ST_FALL: begin
        tmr_en = 1'b1;
        if (tick_c) begin
          if (down_bound) state_next = ST_LOCK;
          else            cmd_next.mv_down = 1'b1;
        end else if (down_edge) begin
          if (down_bound) begin
            state_next = ST_LOCK;
          end else begin
            cmd_next.mv_down = 1'b1;
            tmr_clr          = 1'b1;
          end
        end else if (left_edge && right_edge) begin
          // Contradictory request: drop both.
        end else if (left_edge && !left_bound) begin
          cmd_next.mv_left = 1'b1;
        end else if (right_edge && !right_bound) begin
          cmd_next.mv_right = 1'b1;
        end
      end

      ST_LOCK: begin
        cmd_next.lock = 1'b1;
        scan_row_next = ROW_BOTTOM;
        state_next    = ST_SCAN;
      end

      // Bottom-up row scan; a cleared row is rescanned after CLR_WAIT because
      // the row above has dropped into it.
      ST_SCAN: begin
        if (line_full[scan_row]) begin
          cmd_next.clear_row = 1'b1;
          clear_idx_next     = scan_row;
          score_next         = sat_inc(score);
          state_next         = ST_CLR_WAIT;
        end else if (scan_row == '0) begin
          state_next = ST_SPAWN;
        end else begin
          scan_row_next = scan_row - ROW_W'(1);
        end
      end

      ST_CLR_WAIT: begin
        state_next = ST_SCAN;
      end

      ST_OVER: begin
        if (up_edge) begin
          cmd_next.clear_all = 1'b1;
          score_next         = '0;
          state_next         = ST_SPAWN;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    game_over_next = (state_next == ST_OVER);
  end

  // State, command and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      clear_idx <= '0;
      game_over <= 1'b0;
      score     <= '0;
      scan_row  <= ROW_BOTTOM;
      btn_q     <= '0;
    end else begin
      state     <= state_next;
      cmd       <= cmd_next;
      clear_idx <= clear_idx_next;
      game_over <= game_over_next;
      score     <= score_next;
      scan_row  <= scan_row_next;
      btn_q     <= {btn_up, btn_down, btn_left, btn_right};
    end
  end

  assign mv_left   = cmd.mv_left;
  assign mv_right  = cmd.mv_right;
  assign mv_down   = cmd.mv_down;
  assign lock      = cmd.lock;
  assign spawn     = cmd.spawn;
  assign clear_all = cmd.clear_all;
  assign clear_row = cmd.clear_row;
  assign state_o   = state;

endmodule

// File: tb/tb_tetris_step_ctrl.sv
// Directed bench for tetris_step_ctrl with a gravity divider of 4.
module tb_tetris_step_ctrl;
  import tetris_step_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        btn_left, btn_right, btn_down, btn_up;
  logic        left_bound, right_bound, down_bound, overlap;
  logic [11:0] line_full;
  logic        mv_left, mv_right, mv_down, lock, spawn, clear_all, clear_row;
  logic [3:0]  clear_idx;
  logic        game_over;
  logic [15:0] score;
  logic [2:0]  state_o;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
  localparam logic [2:0] S_SPN  = 3'(ST_SPAWN);
  localparam logic [2:0] S_CHK  = 3'(ST_SPAWN_CHK);
  localparam logic [2:0] S_FALL = 3'(ST_FALL);
  localparam logic [2:0] S_LOCK = 3'(ST_LOCK);
  localparam logic [2:0] S_SCAN = 3'(ST_SCAN);
  localparam logic [2:0] S_CLRW = 3'(ST_CLR_WAIT);
  localparam logic [2:0] S_OVER = 3'(ST_OVER);

  // Command vector order: {mv_left, mv_right, mv_down, lock, spawn, clear_all, clear_row}
  localparam logic [6:0] C_NONE = 7'b000_0000;
  localparam logic [6:0] C_LEFT = 7'b100_0000;
  localparam logic [6:0] C_RGHT = 7'b010_0000;
  localparam logic [6:0] C_DOWN = 7'b001_0000;
  localparam logic [6:0] C_LOCK = 7'b000_1000;
  localparam logic [6:0] C_SPWN = 7'b000_0100;
  localparam logic [6:0] C_CALL = 7'b000_0010;
  localparam logic [6:0] C_CROW = 7'b000_0001;

  // Input vector order: {up, down, left, right, left_bound, right_bound, down_bound, overlap}
  localparam logic [7:0] I_UP = 8'b1000_0000;
  localparam logic [7:0] I_DN = 8'b0100_0000;
  localparam logic [7:0] I_LF = 8'b0010_0000;
  localparam logic [7:0] I_RT = 8'b0001_0000;
  localparam logic [7:0] I_LB = 8'b0000_1000;
  localparam logic [7:0] I_RB = 8'b0000_0100;
  localparam logic [7:0] I_DB = 8'b0000_0010;
  localparam logic [7:0] I_OV = 8'b0000_0001;

  logic [6:0] cmd_obs;
  logic [9:0] obs;
  assign cmd_obs = {mv_left, mv_right, mv_down, lock, spawn, clear_all, clear_row};
  assign obs     = {state_o, cmd_obs};

  tetris_step_ctrl #(
    .GRID_H      (12),
    .GRAVITY_DIV (4),
    .ROW_W       (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_down    (btn_down),
    .btn_up      (btn_up),
    .left_bound  (left_bound),
    .right_bound (right_bound),
    .down_bound  (down_bound),
    .overlap     (overlap),
    .line_full   (line_full),
    .mv_left     (mv_left),
    .mv_right    (mv_right),
    .mv_down     (mv_down),
    .lock        (lock),
    .spawn       (spawn),
    .clear_all   (clear_all),
    .clear_row   (clear_row),
    .clear_idx   (clear_idx),
    .game_over   (game_over),
    .score       (score),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] v);
    {btn_up, btn_down, btn_left, btn_right, left_bound, right_bound, down_bound, overlap} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(8'h00);
    line_full = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs !== {S_IDLE, C_NONE}) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs, {S_IDLE, C_NONE});
    end
    vectors++;
    if ({game_over, score, clear_idx} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_status: got go=%b score=%0d idx=%0d want all zero", game_over, score, clear_idx);
    end
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs !== {S_IDLE, C_NONE}) begin
        miscompares++;
        $display("FAIL idle_quiet[%0d]: got %b want %b", i, obs, {S_IDLE, C_NONE});
      end
    end
  endtask

  task automatic test_start_gravity();
    logic [7:0] st [11];
    logic [9:0] ex [11];
    st = '{I_UP, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ex = '{{S_SPN, C_CALL}, {S_CHK, C_SPWN}, {S_FALL, C_NONE},
           {S_FALL, C_NONE}, {S_FALL, C_NONE}, {S_FALL, C_NONE}, {S_FALL, C_DOWN},
           {S_FALL, C_NONE}, {S_FALL, C_NONE}, {S_FALL, C_NONE}, {S_FALL, C_DOWN}};
    for (int i = 0; i < 11; i++) begin
      drive(st[i]);
      step();
      vectors++;
      if (obs !== ex[i]) begin
        miscompares++;
        $display("FAIL start_gravity[%0d]: got %b want %b", i, obs, ex[i]);
      end
    end
    vectors++;
    if ({game_over, score} !== 17'd0) begin
      miscompares++;
      $display("FAIL start_status: got go=%b score=%0d want 0/0", game_over, score);
    end
  endtask

  task automatic test_left_right();
    logic [7:0] st [7];
    logic [9:0] ex [7];
    st = '{I_LF | I_RT, 8'h00, I_LF | I_LB, 8'h00, I_LF, I_LF, 8'h00};
    ex = '{{S_FALL, C_NONE}, {S_FALL, C_NONE}, {S_FALL, C_NONE}, {S_FALL, C_DOWN},
           {S_FALL, C_LEFT}, {S_FALL, C_NONE}, {S_FALL, C_NONE}};
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      step();
      vectors++;
      if (obs !== ex[i]) begin
        miscompares++;
        $display("FAIL left_right[%0d]: got %b want %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_gravity_priority();
    logic [7:0] st [10];
    logic [9:0] ex [10];
    st = '{I_LF, I_LF, I_DN, 8'h00, 8'h00, 8'h00, 8'h00, I_RT, 8'h00, I_RT | I_RB};
    ex = '{{S_FALL, C_DOWN}, {S_FALL, C_NONE}, {S_FALL, C_DOWN}, {S_FALL, C_NONE},
           {S_FALL, C_NONE}, {S_FALL, C_NONE}, {S_FALL, C_DOWN}, {S_FALL, C_RGHT},
           {S_FALL, C_NONE}, {S_FALL, C_NONE}};
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      step();
      vectors++;
      if (obs !== ex[i]) begin
        miscompares++;
        $display("FAIL gravity_priority[%0d]: got %b want %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_lock_single_row();
    drive(I_DB);
    step();
    vectors++;
    if (obs !== {S_LOCK, C_NONE}) begin
      miscompares++;
      $display("FAIL lock_on_tick: got %b want %b", obs, {S_LOCK, C_NONE});
    end
    drive(8'h00);
    step();
    vectors++;
    if (obs !== {S_SCAN, C_LOCK}) begin
      miscompares++;
      $display("FAIL lock_pulse: got %b want %b", obs, {S_SCAN, C_LOCK});
    end
    line_full = 12'b1000_0000_0000;
    step();
    vectors++;
    if ({obs, clear_idx, score} !== {S_CLRW, C_CROW, 4'd11, 16'd1}) begin
      miscompares++;
      $display("FAIL clear_row11: got %b idx=%0d score=%0d want %b idx=11 score=1", obs, clear_idx, score, {S_CLRW, C_CROW});
    end
    line_full = '0;
    step();
    vectors++;
    if (obs !== {S_SCAN, C_NONE}) begin
      miscompares++;
      $display("FAIL clr_wait_back: got %b want %b", obs, {S_SCAN, C_NONE});
    end
    for (int r = 11; r >= 1; r--) begin
      step();
      vectors++;
      if (obs !== {S_SCAN, C_NONE}) begin
        miscompares++;
        $display("FAIL scan_row%0d: got %b want %b", r, obs, {S_SCAN, C_NONE});
      end
    end
    step();
    vectors++;
    if (obs !== {S_SPN, C_NONE}) begin
      miscompares++;
      $display("FAIL scan_done: got %b want %b", obs, {S_SPN, C_NONE});
    end
    step();
    step();
    vectors++;
    if ({obs, score} !== {S_FALL, C_NONE, 16'd1}) begin
      miscompares++;
      $display("FAIL respawn_fall: got %b score=%0d want %b score=1", obs, score, {S_FALL, C_NONE});
    end
  endtask

  task automatic test_two_rows();
    drive(I_DN | I_DB);
    step();
    vectors++;
    if (obs !== {S_LOCK, C_NONE}) begin
      miscompares++;
      $display("FAIL lock_on_drop: got %b want %b", obs, {S_LOCK, C_NONE});
    end
    drive(8'h00);
    step();
    line_full = 12'b1100_0000_0000;
    step();
    vectors++;
    if ({obs, clear_idx, score} !== {S_CLRW, C_CROW, 4'd11, 16'd2}) begin
      miscompares++;
      $display("FAIL two_rows_first: got %b idx=%0d score=%0d want idx=11 score=2", obs, clear_idx, score);
    end
    line_full = 12'b1000_0000_0000;
    step();
    step();
    vectors++;
    if ({obs, clear_idx, score} !== {S_CLRW, C_CROW, 4'd11, 16'd3}) begin
      miscompares++;
      $display("FAIL two_rows_second: got %b idx=%0d score=%0d want idx=11 score=3", obs, clear_idx, score);
    end
    line_full = '0;
    repeat (13) step();
    vectors++;
    if (obs !== {S_SPN, C_NONE}) begin
      miscompares++;
      $display("FAIL two_rows_scan_done: got %b want %b", obs, {S_SPN, C_NONE});
    end
    step();
    vectors++;
    if (obs !== {S_CHK, C_SPWN}) begin
      miscompares++;
      $display("FAIL two_rows_spawn: got %b want %b", obs, {S_CHK, C_SPWN});
    end
  endtask

  task automatic test_game_over();
    logic [7:0] st [6];
    drive(I_OV);
    step();
    vectors++;
    if ({obs, game_over} !== {S_OVER, C_NONE, 1'b1}) begin
      miscompares++;
      $display("FAIL enter_over: got %b go=%b want %b go=1", obs, game_over, {S_OVER, C_NONE});
    end
    st = '{I_LF | I_OV, I_OV, I_RT | I_OV, I_OV, I_DN | I_OV, I_LF | I_RT | I_DN | I_OV};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      step();
      vectors++;
      if ({obs, game_over, score} !== {S_OVER, C_NONE, 1'b1, 16'd3}) begin
        miscompares++;
        $display("FAIL over_hold[%0d]: got %b go=%b score=%0d want %b go=1 score=3", i, obs, game_over, score, {S_OVER, C_NONE});
      end
    end
    drive(I_UP);
    step();
    vectors++;
    if ({obs, game_over, score} !== {S_SPN, C_CALL, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL restart: got %b go=%b score=%0d want %b go=0 score=0", obs, game_over, score, {S_SPN, C_CALL});
    end
    drive(8'h00);
    step();
    vectors++;
    if (obs !== {S_CHK, C_SPWN}) begin
      miscompares++;
      $display("FAIL restart_spawn: got %b want %b", obs, {S_CHK, C_SPWN});
    end
    step();
    drive(I_UP);
    step();
    vectors++;
    if (obs !== {S_FALL, C_NONE}) begin
      miscompares++;
      $display("FAIL up_ignored_in_fall: got %b want %b", obs, {S_FALL, C_NONE});
    end
    drive(8'h00);
  endtask

  task automatic test_reset_mid_scan();
    drive(I_DN | I_DB);
    step();
    drive(8'h00);
    step();
    line_full = 12'b1000_0000_0000;
    step();
    vectors++;
    if ({obs, score} !== {S_CLRW, C_CROW, 16'd1}) begin
      miscompares++;
      $display("FAIL pre_reset_clear: got %b score=%0d want %b score=1", obs, score, {S_CLRW, C_CROW});
    end
    line_full = '0;
    step();
    step();
    resetn = 1'b0;
    #2;
    vectors++;
    if ({obs, game_over, score, clear_idx} !== {S_IDLE, C_NONE, 1'b0, 16'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got %b go=%b score=%0d idx=%0d want idle/zero", obs, game_over, score, clear_idx);
    end
    step();
    resetn = 1'b1;
    step();
    vectors++;
    if (obs !== {S_IDLE, C_NONE}) begin
      miscompares++;
      $display("FAIL after_reset_idle: got %b want %b", obs, {S_IDLE, C_NONE});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start_gravity();
    test_left_right();
    test_gravity_priority();
    test_lock_single_row();
    test_two_rows();
    test_game_over();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
